// File: rtl/mvb_decode_ctrl_if.sv
// Bus bundle between the MVB receive decoder (master side) and its consumer (slave side).
// Stats ports exist only when MVB_RX_STATS_EN is defined.
interface mvb_decode_ctrl_if;
    logic        rx_in;
    logic [6:0]  exp_words;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic [1:0]  frame_type;
    logic        frame_busy;
    logic [6:0]  word_cnt;
    logic        crc_err;
    logic        manch_err;
    logic        frame_done;
    logic        frame_ok;
`ifdef MVB_RX_STATS_EN
    logic [7:0]  frame_cnt;
    logic [7:0]  err_cnt;
`endif

    modport master (
        input  rx_in, exp_words,
        output rx_data, rx_valid, frame_type, frame_busy, word_cnt,
        output crc_err, manch_err, frame_done, frame_ok
`ifdef MVB_RX_STATS_EN
        , output frame_cnt, err_cnt
`endif
    );

    modport slave (
        output rx_in, exp_words,
        input  rx_data, rx_valid, frame_type, frame_busy, word_cnt,
        input  crc_err, manch_err, frame_done, frame_ok
`ifdef MVB_RX_STATS_EN
        , input frame_cnt, err_cnt
`endif
    );
endinterface

// File: rtl/mvb_decode_ctrl.sv
// MVB receive control: Manchester half-bit recovery, SD hunt, word/check decode, ED detection.
// Define MVB_RX_STATS_EN to add saturating good/bad frame counters.
module mvb_decode_ctrl #(
    parameter logic [15:0] MASTER_SD = 16'h9C6A,
    parameter logic [15:0] SLAVE_SD  = 16'h9A6C,
    parameter int unsigned IDLE_HB   = 8
) (
    input logic               clk_6M,
    input logic               rst,
    mvb_decode_ctrl_if.master bus
);
    typedef enum logic [2:0] {StIdle, StHunt, StData, StChk, StEd, StDone} state_e;

    localparam logic [7:0] IdleHbM1 = 8'(IDLE_HB - 1);

    logic        sync1, rx_s, rx_d, strobe;
    logic [7:0]  idle_cnt;
    state_e      state;
    logic [15:0] sr, word;
    logic        half, phase;
    logic [3:0]  bit_cnt;
    logic [1:0]  grp_cnt;
    logic [6:0]  crc, chk_sr, exp_q;
    logic        par;
    logic [15:0] rx_data;
    logic        rx_valid, frame_busy, crc_err, manch_err, frame_done, frame_ok;
    logic [1:0]  frame_type;
    logic [6:0]  word_cnt;

    logic        edge_det, idle_hit, pair_bad, bit_val, bit_good, crc_fb, abort, grp_end, ed_ok;
    logic [15:0] sr_nxt;
    logic [6:0]  crc_nxt;
    logic [7:0]  chk_exp;

    always_comb begin
        edge_det = rx_s ^ rx_d;
        idle_hit = strobe && !edge_det && (idle_cnt >= IdleHbM1);
        sr_nxt   = {sr[14:0], rx_s};
        // Valid cell is 10 or 01, so the bit value is the first half.
        pair_bad = (half == rx_s);
        bit_val  = half;
        bit_good = strobe && phase && !pair_bad;
        crc_fb   = bit_val ^ crc[6];
        crc_nxt  = {crc[5:0], 1'b0} ^ (crc_fb ? 7'h65 : 7'h00);
        chk_exp  = ~{crc, par ^ (^crc)};
        grp_end  = (grp_cnt == 2'd3) || (word_cnt + 7'd1 == exp_q);
        ed_ok    = half && rx_s;
        abort    = ((state == StData) || (state == StChk)) &&
                   (idle_hit || (strobe && phase && pair_bad));
    end

    always_ff @(posedge clk_6M) begin
        if (!rst) begin
            sync1    <= 1'b0;
            rx_s     <= 1'b0;
            rx_d     <= 1'b0;
            strobe   <= 1'b0;
            idle_cnt <= 8'd0;
        end else begin
            sync1  <= bus.rx_in;
            rx_s   <= sync1;
            rx_d   <= rx_s;
            strobe <= edge_det ? 1'b1 : ~strobe;
            if (edge_det) begin
                idle_cnt <= 8'd0;
            end else if (strobe && idle_cnt != 8'hFF) begin
                idle_cnt <= idle_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_6M) begin
        if (!rst) begin
            state      <= StIdle;
            sr         <= 16'd0;
            word       <= 16'd0;
            half       <= 1'b0;
            phase      <= 1'b0;
            bit_cnt    <= 4'd0;
            grp_cnt    <= 2'd0;
            crc        <= 7'd0;
            par        <= 1'b0;
            chk_sr     <= 7'd0;
            exp_q      <= 7'd0;
            rx_data    <= 16'd0;
            rx_valid   <= 1'b0;
            frame_type <= 2'b00;
            frame_busy <= 1'b0;
            word_cnt   <= 7'd0;
            crc_err    <= 1'b0;
            manch_err  <= 1'b0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
        end else begin
            rx_valid   <= 1'b0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            if (strobe && !phase) begin
                half <= rx_s;
            end
            if (abort) begin
                manch_err  <= 1'b1;
                frame_busy <= 1'b0;
                frame_done <= 1'b1;
                state      <= StDone;
            end else begin
                unique case (state)
                    StIdle: begin
                        sr <= 16'd0;
                        if (rx_s && !rx_d) state <= StHunt;
                    end
                    StHunt: begin
                        if (idle_hit) begin
                            state <= StIdle;
                        end else if (strobe) begin
                            sr <= sr_nxt;
                            if (sr_nxt == MASTER_SD || sr_nxt == SLAVE_SD) begin
                                frame_type <= (sr_nxt == MASTER_SD) ? 2'b01 : 2'b10;
                                exp_q      <= bus.exp_words;
                                crc_err    <= 1'b0;
                                manch_err  <= 1'b0;
                                word_cnt   <= 7'd0;
                                frame_busy <= 1'b1;
                                phase      <= 1'b0;
                                bit_cnt    <= 4'd0;
                                grp_cnt    <= 2'd0;
                                crc        <= 7'd0;
                                par        <= 1'b0;
                                // A zero-word request still gets its (empty) check group.
                                state      <= (bus.exp_words == 7'd0) ? StChk : StData;
                            end
                        end
                    end
                    StData: begin
                        if (strobe) phase <= ~phase;
                        if (bit_good) begin
                            word    <= {word[14:0], bit_val};
                            crc     <= crc_nxt;
                            par     <= par ^ bit_val;
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd15) begin
                                rx_data  <= {word[14:0], bit_val};
                                rx_valid <= 1'b1;
                                word_cnt <= word_cnt + 7'd1;
                                grp_cnt  <= grp_end ? 2'd0 : grp_cnt + 2'd1;
                                if (grp_end) state <= StChk;
                            end
                        end
                    end
                    StChk: begin
                        if (strobe) phase <= ~phase;
                        if (bit_good) begin
                            chk_sr  <= {chk_sr[5:0], bit_val};
                            bit_cnt <= bit_cnt + 4'd1;
                            if (bit_cnt == 4'd7) begin
                                if ({chk_sr, bit_val} != chk_exp) crc_err <= 1'b1;
                                crc     <= 7'd0;
                                par     <= 1'b0;
                                bit_cnt <= 4'd0;
                                state   <= (word_cnt < exp_q) ? StData : StEd;
                            end
                        end
                    end
                    StEd: begin
                        if (strobe) phase <= ~phase;
                        if (strobe && phase) begin
                            if (!ed_ok) manch_err <= 1'b1;
                            frame_ok   <= ed_ok && !crc_err && (word_cnt == exp_q);
                            frame_busy <= 1'b0;
                            frame_done <= 1'b1;
                            state      <= StDone;
                        end
                    end
                    StDone: begin
                        sr    <= 16'd0;
                        phase <= 1'b0;
                        state <= StIdle;
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

    assign bus.rx_data    = rx_data;
    assign bus.rx_valid   = rx_valid;
    assign bus.frame_type = frame_type;
    assign bus.frame_busy = frame_busy;
    assign bus.word_cnt   = word_cnt;
    assign bus.crc_err    = crc_err;
    assign bus.manch_err  = manch_err;
    assign bus.frame_done = frame_done;
    assign bus.frame_ok   = frame_ok;

`ifdef MVB_RX_STATS_EN
    logic [7:0] frame_cnt, err_cnt;

    always_ff @(posedge clk_6M) begin
        if (!rst) begin
            frame_cnt <= 8'd0;
            err_cnt   <= 8'd0;
        end else if (frame_done) begin
            if (frame_ok && frame_cnt != 8'hFF) frame_cnt <= frame_cnt + 8'd1;
            if (!frame_ok && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
        end
    end

    assign bus.frame_cnt = frame_cnt;
    assign bus.err_cnt   = err_cnt;
`endif
endmodule
